// File: rtl/pattern_tx_pkg.sv
// Shared types and constants for the pattern_tx serial transmitter.
// Optional parity bit is controlled by the PATTERN_TX_PARITY_EN macro.
package pattern_tx_pkg;

    localparam int unsigned DEFAULT_BIT_TICKS = 4;
    localparam logic [7:0]  RECOG_PATTERN     = 8'h04;

`ifdef PATTERN_TX_PARITY_EN
    typedef enum logic [1:0] {
        TX_IDLE   = 2'd0,
        TX_SHIFT  = 2'd1,
        TX_DONE   = 2'd2,
        TX_PARITY = 2'd3
    } tx_state_t;
`else
    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_SHIFT = 2'd1,
        TX_DONE  = 2'd2
    } tx_state_t;
`endif

endpackage

// File: rtl/pattern_tx_bit_tick_gen.sv
// Per-bit hold counter: counts 0..BIT_TICKS-1 while enabled and flags the terminal count.
module bit_tick_gen #(
    parameter int unsigned BIT_TICKS = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic tick_last
);

    localparam int unsigned CNT_W = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick_last = enable && (cnt_q == CNT_W'(BIT_TICKS - 1));

    // Next count: clear wins, otherwise wrap at terminal count
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = tick_last ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pattern_tx.sv
// Serial transmitter: captures a word on start and shifts it out MSB-first,
// each bit held BIT_TICKS cycles, followed by a one-cycle done pulse.
// Define PATTERN_TX_PARITY_EN to append an even-parity bit to each frame.
module pattern_tx
    import pattern_tx_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned BIT_TICKS = DEFAULT_BIT_TICKS
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    output logic              ser_out,
    output logic              ser_valid,
    output logic              busy,
    output logic              done
);

    localparam int unsigned BIT_W = $clog2(DATA_W);

    tx_state_t         state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic              tick_last;
    logic              tick_clear;
    logic              ser_out_d, ser_valid_d, busy_d, done_d;
`ifdef PATTERN_TX_PARITY_EN
    logic              par_q, par_d;
`endif

    assign tick_clear = (state_q == TX_IDLE) || (state_q == TX_DONE);

    bit_tick_gen #(
        .BIT_TICKS (BIT_TICKS)
    ) u_tick (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (tick_clear),
        .enable    (!tick_clear),
        .tick_last (tick_last)
    );

    // State, shift register and bit counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= TX_IDLE;
            shreg_q <= '0;
            bit_q   <= '0;
`ifdef PATTERN_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            bit_q   <= bit_d;
`ifdef PATTERN_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        bit_d   = bit_q;
`ifdef PATTERN_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            TX_IDLE: begin
                if (start) begin
                    shreg_d = data_in;
                    bit_d   = '0;
`ifdef PATTERN_TX_PARITY_EN
                    par_d   = ^data_in;
`endif
                    state_d = TX_SHIFT;
                end
            end
            TX_SHIFT: begin
                if (tick_last) begin
                    shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
                    bit_d   = bit_q + BIT_W'(1);
                    if (bit_q == BIT_W'(DATA_W - 1)) begin
                        bit_d   = '0;
`ifdef PATTERN_TX_PARITY_EN
                        state_d = TX_PARITY;
`else
                        state_d = TX_DONE;
`endif
                    end
                end
            end
`ifdef PATTERN_TX_PARITY_EN
            TX_PARITY: begin
                if (tick_last) begin
                    state_d = TX_DONE;
                end
            end
`endif
            TX_DONE: begin
                state_d = TX_IDLE;
            end
            default: begin
                state_d = TX_IDLE;
            end
        endcase
    end

    // Output values for the upcoming cycle, decoded from next state
    always_comb begin
        ser_out_d   = 1'b0;
        ser_valid_d = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        case (state_d)
            TX_SHIFT: begin
                ser_out_d   = shreg_d[DATA_W-1];
                ser_valid_d = 1'b1;
                busy_d      = 1'b1;
            end
`ifdef PATTERN_TX_PARITY_EN
            TX_PARITY: begin
                ser_out_d   = par_d;
                ser_valid_d = 1'b1;
                busy_d      = 1'b1;
            end
`endif
            TX_DONE: begin
                done_d = 1'b1;
            end
            default: begin
                ser_out_d = 1'b0;
            end
        endcase
    end

    // Registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ser_out   <= 1'b0;
            ser_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            ser_out   <= ser_out_d;
            ser_valid <= ser_valid_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

endmodule

// File: tb/tb_pattern_tx.sv
// Bench for pattern_tx: two instances (BIT_TICKS=4 and BIT_TICKS=1) driven with
// directed and random frames, checked against a per-cycle frame model.
module tb_pattern_tx;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] start;
    logic [7:0] data0, data1;
    logic [1:0] so, sv, bs, dn;

    int n_checks = 0;
    int n_err    = 0;

`ifdef PATTERN_TX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif

    always #5 clk = ~clk;

    pattern_tx #(.DATA_W(8), .BIT_TICKS(4)) u_dut4 (
        .clk(clk), .reset_n(reset_n), .start(start[0]), .data_in(data0),
        .ser_out(so[0]), .ser_valid(sv[0]), .busy(bs[0]), .done(dn[0])
    );

    pattern_tx #(.DATA_W(8), .BIT_TICKS(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .start(start[1]), .data_in(data1),
        .ser_out(so[1]), .ser_valid(sv[1]), .busy(bs[1]), .done(dn[1])
    );

    function automatic int bt_of(input int idx);
        return (idx == 0) ? 4 : 1;
    endfunction

    function automatic int frame_len(input int idx);
        return (8 + PAR_BITS) * bt_of(idx);
    endfunction

    // Expected serial bit in frame cycle c (1-based): data MSB first, then parity
    function automatic logic exp_bit(input logic [7:0] w, input int idx, input int c);
        int k;
        k = (c - 1) / bt_of(idx);
        if (k < 8) return w[7-k];
        return ^w;
    endfunction

    task automatic check(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input int idx, input string tag, input logic e_so,
                              input logic e_sv, input logic e_bs, input logic e_dn);
        check($sformatf("%s ser_out", tag),   so[idx], e_so);
        check($sformatf("%s ser_valid", tag), sv[idx], e_sv);
        check($sformatf("%s busy", tag),      bs[idx], e_bs);
        check($sformatf("%s done", tag),      dn[idx], e_dn);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int idx, input logic [7:0] w);
        if (idx == 0) data0 = w;
        else          data1 = w;
    endtask

    // Send one frame and check every cycle; optionally disturb start/data_in at cycle disturb_c
    task automatic send_frame(input int idx, input logic [7:0] w, input int disturb_c);
        int f;
        f = frame_len(idx);
        set_data(idx, w);
        start[idx] = 1'b1;
        step();
        start[idx] = 1'b0;
        for (int c = 1; c <= f + 1; c++) begin
            if (c <= f)
                check_outs(idx, $sformatf("d%0d w%02h c%0d", idx, w, c), exp_bit(w, idx, c), 1'b1, 1'b1, 1'b0);
            else
                check_outs(idx, $sformatf("d%0d w%02h done", idx, w), 1'b0, 1'b0, 1'b0, 1'b1);
            if (c == disturb_c) begin
                start[idx] = 1'b1;
                set_data(idx, 8'h00);
            end else if (c == disturb_c + 1) begin
                start[idx] = 1'b0;
            end
            step();
        end
        for (int c = 0; c < 3; c++) begin
            check_outs(idx, $sformatf("d%0d w%02h idle%0d", idx, w, c), 1'b0, 1'b0, 1'b0, 1'b0);
            step();
        end
    endtask

    initial begin
        logic [7:0] w;
        int         idx;
        int         f;
        int         per;
        int         p;

        // Reset held with start asserted: everything stays quiet
        reset_n = 1'b0;
        start   = 2'b11;
        data0   = 8'h04;
        data1   = 8'h04;
        for (int i = 0; i < 3; i++) begin
            step();
            check_outs(0, "rst d0", 1'b0, 1'b0, 1'b0, 1'b0);
            check_outs(1, "rst d1", 1'b0, 1'b0, 1'b0, 1'b0);
        end
        start   = 2'b00;
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_outs(0, "post-rst d0", 1'b0, 1'b0, 1'b0, 1'b0);
            check_outs(1, "post-rst d1", 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // Basic frames with the recognizer pattern
        send_frame(0, 8'h04, -1);
        send_frame(1, 8'h04, -1);

        // start and data_in changes during a frame are ignored
        send_frame(1, 8'hA5, 3);
        send_frame(0, 8'h5A, 5);

        // Random frames on both instances
        for (int i = 0; i < 8; i++) begin
            idx = int'($urandom_range(0, 1));
            w   = 8'($urandom);
            send_frame(idx, w, -1);
        end

        // Reset in cycle 10 of a frame abandons it
        w = 8'($urandom);
        data0 = w;
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        for (int c = 2; c <= 10; c++) step();
        check_outs(0, "pre-abort c10", exp_bit(w, 0, 10), 1'b1, 1'b1, 1'b0);
        #2 reset_n = 1'b0;
        #1 check_outs(0, "async abort", 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        step();
        check_outs(0, "abort held", 1'b0, 1'b0, 1'b0, 1'b0);
        #3 reset_n = 1'b1;
        for (int i = 0; i < 4 + frame_len(0); i++) begin
            step();
            check_outs(0, $sformatf("abort idle%0d", i), 1'b0, 1'b0, 1'b0, 1'b0);
        end
        send_frame(0, 8'($urandom), -1);

        // start held high: back-to-back frames every F+2 cycles
        w = 8'($urandom);
        data1 = w;
        f   = frame_len(1);
        per = f + 2;
        start[1] = 1'b1;
        step();
        for (int t = 1; t <= 3 * per; t++) begin
            p = (t - 1) % per + 1;
            if (p <= f)
                check_outs(1, $sformatf("b2b t%0d", t), exp_bit(w, 1, p), 1'b1, 1'b1, 1'b0);
            else if (p == f + 1)
                check_outs(1, $sformatf("b2b t%0d", t), 1'b0, 1'b0, 1'b0, 1'b1);
            else
                check_outs(1, $sformatf("b2b t%0d", t), 1'b0, 1'b0, 1'b0, 1'b0);
            if (t == 3 * per) start[1] = 1'b0;
            step();
        end
        for (int i = 0; i < 2; i++) begin
            check_outs(1, $sformatf("b2b end%0d", i), 1'b0, 1'b0, 1'b0, 1'b0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
